// File: rtl/random_wait_param.sv
// Start-triggered wait of (r+1)<<SHIFT cycles from a free-running random source, then a 1-cycle done pulse; RWAIT_LFSR_EN selects a 16-bit LFSR source.
// busy is high from the accept edge until expiry, and done follows that edge. No backpressure: start/abort are sampled every edge, and abort wins.
module random_wait_param #(
    parameter int RAND_W = 3,
    parameter int SHIFT  = 10,
    parameter int CNT_W  = RAND_W + 1 + SHIFT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_wait,
    input  logic              abort,
    output logic              rwait_done,
    output logic              busy,
    output logic [RAND_W-1:0] rand_q,
    output logic [CNT_W-1:0]  wait_len
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [CNT_W-1:0]  r_wait_len;
    logic [CNT_W-1:0]  w_len_new;
    logic [RAND_W-1:0] r_rand_q;
    logic [RAND_W-1:0] w_src;
    logic              w_capture;
    logic              r_done;
    logic              r_busy;

`ifdef RWAIT_LFSR_EN
    // Fibonacci LFSR for x^16+x^14+x^13+x^11+1; a non-zero seed keeps it off the all-zero state.
    logic [15:0] r_lfsr;
    logic        w_lfsr_fb;

    assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= 16'hACE1;
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
        end
    end

    assign w_src = r_lfsr[RAND_W-1:0];
`else
    logic [RAND_W-1:0] r_src;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_src <= '0;
        end else begin
            r_src <= r_src + RAND_W'(1);
        end
    end

    assign w_src = r_src;
`endif

    // The +1 is done one bit wider than r, so r = max yields 2^RAND_W steps without wrapping.
    assign w_len_new = CNT_W'({1'b0, w_src} + {{RAND_W{1'b0}}, 1'b1}) << SHIFT;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (start_wait) begin
                    w_capture   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (abort) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else if (start_wait) begin
                    w_capture   = 1'b1;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == r_wait_len - CNT_W'(1)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_DONE;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                end
            end
            S_DONE: begin
                w_cnt_nxt = '0;
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (start_wait) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_WAIT;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_rand_q   <= '0;
            r_wait_len <= '0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= (w_state_nxt == S_DONE);
            r_busy  <= (w_state_nxt == S_WAIT);
            if (w_capture) begin
                r_rand_q   <= w_src;
                r_wait_len <= w_len_new;
            end
        end
    end

    assign rwait_done = r_done;
    assign busy       = r_busy;
    assign rand_q     = r_rand_q;
    assign wait_len   = r_wait_len;

endmodule

// File: tb/tb_random_wait_param.sv
// Randomised bench for random_wait_param against a countdown reference model of the wait behaviour.
module tb_random_wait_param;

`ifdef RWAIT_LFSR_EN
    localparam int RW = 3;
`else
    localparam int RW = 2;
`endif
    localparam int SH = 2;
    localparam int CW = RW + 1 + SH;
`ifdef RWAIT_LFSR_EN
    localparam int FIRST_R = 1;   // 16'hACE1 low bits
`else
    localparam int FIRST_R = 0;
`endif
    localparam int FIRST_LEN = (FIRST_R + 1) * (1 << SH);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_wait = 1'b0;
    logic          abort = 1'b0;
    logic          rwait_done;
    logic          busy;
    logic [RW-1:0] rand_q;
    logic [CW-1:0] wait_len;

    random_wait_param #(.RAND_W(RW), .SHIFT(SH), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start_wait(start_wait), .abort(abort),
        .rwait_done(rwait_done), .busy(busy), .rand_q(rand_q), .wait_len(wait_len)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: edges since reset release drive the source; the wait is a countdown.
    int            m_rel = 0;
    logic [15:0]   m_lfsr = 16'hACE1;
    bit            m_active = 1'b0;
    int            m_rem = 0;
    logic          m_done = 1'b0;
    logic          m_busy = 1'b0;
    logic [RW-1:0] m_r = '0;
    logic [CW-1:0] m_len = '0;

    function automatic int model_src();
`ifdef RWAIT_LFSR_EN
        return int'(m_lfsr[RW-1:0]);
`else
        return m_rel % (1 << RW);
`endif
    endfunction

    task automatic model_edge();
        int cur;
        if (rst) begin
            m_rel = 0; m_lfsr = 16'hACE1; m_active = 1'b0; m_done = 1'b0;
            m_r = '0; m_len = '0; m_rem = 0;
        end else begin
            cur = model_src();
            m_done = 1'b0;
            if (abort) begin
                m_active = 1'b0;
            end else if (start_wait) begin
                m_r = RW'(cur);
                m_rem = (cur + 1) * (1 << SH);
                m_len = CW'(m_rem);
                m_active = 1'b1;
            end else if (m_active) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_active = 1'b0;
                    m_done = 1'b1;
                end
            end
            m_rel++;
            m_lfsr = {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
        end
        m_busy = m_active;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Runs n edges; reports first done offset, done/busy counts and cycles disagreeing with the model.
    task automatic observe(input int n, output int first, output int dcnt, output int bcnt, output int mm);
        first = -1; dcnt = 0; bcnt = 0; mm = 0;
        for (int i = 1; i <= n; i++) begin
            step();
            if (rwait_done === 1'b1) begin
                dcnt++;
                if (first < 0) first = i;
            end
            if (busy === 1'b1) bcnt++;
            if (rwait_done !== m_done || busy !== m_busy || rand_q !== m_r || wait_len !== m_len) mm++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; start_wait = 1'b0; abort = 1'b0;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        start_wait = 1'b1;
        step();
        start_wait = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start_wait = 1'b0; abort = 1'b0;
        step(); step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (rwait_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%0b exp=0", rwait_done); end
        checks++; if (rand_q !== '0) begin errors++; $display("FAIL reset_rand_q got=%0d exp=0", rand_q); end
        checks++; if (wait_len !== '0) begin errors++; $display("FAIL reset_wait_len got=%0d exp=0", wait_len); end
        rst = 1'b0;
    endtask

    task automatic test_first_start();
        int first, dcnt, bcnt, mm;
        pulse_start();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL first_busy got=%0b exp=1", busy); end
        checks++; if (rand_q !== RW'(FIRST_R)) begin errors++; $display("FAIL first_rand_q got=%0d exp=%0d", rand_q, FIRST_R); end
        checks++; if (wait_len !== CW'(FIRST_LEN)) begin errors++; $display("FAIL first_wait_len got=%0d exp=%0d", wait_len, FIRST_LEN); end
        observe(FIRST_LEN + 4, first, dcnt, bcnt, mm);
        checks++; if (first != FIRST_LEN) begin errors++; $display("FAIL first_done_edge got=%0d exp=%0d", first, FIRST_LEN); end
        checks++; if (dcnt != 1) begin errors++; $display("FAIL first_done_count got=%0d exp=1", dcnt); end
        checks++; if (bcnt + 1 != FIRST_LEN) begin errors++; $display("FAIL first_busy_cycles got=%0d exp=%0d", bcnt + 1, FIRST_LEN); end
        checks++; if (mm != 0) begin errors++; $display("FAIL first_model got=%0d exp=0", mm); end
    endtask

`ifndef RWAIT_LFSR_EN
    task automatic test_source_max();
        int first, dcnt, bcnt, mm;
        do_reset();
        step(); step();
        pulse_start();
        checks++; if (rand_q !== 2'd2) begin errors++; $display("FAIL src2_rand_q got=%0d exp=2", rand_q); end
        checks++; if (wait_len !== 5'd12) begin errors++; $display("FAIL src2_wait_len got=%0d exp=12", wait_len); end
        observe(12, first, dcnt, bcnt, mm);
        checks++; if (first != 12) begin errors++; $display("FAIL src2_done_edge got=%0d exp=12", first); end
        observe(4, first, dcnt, bcnt, mm);
        checks++; if (dcnt != 0) begin errors++; $display("FAIL src2_idle_done got=%0d exp=0", dcnt); end
        pulse_start();
        checks++; if (rand_q !== 2'd3) begin errors++; $display("FAIL max_rand_q got=%0d exp=3", rand_q); end
        checks++; if (wait_len !== 5'd16) begin errors++; $display("FAIL max_wait_len got=%0d exp=16", wait_len); end
        observe(20, first, dcnt, bcnt, mm);
        checks++; if (first != 16) begin errors++; $display("FAIL max_done_edge got=%0d exp=16", first); end
        checks++; if (dcnt != 1 || mm != 0) begin errors++; $display("FAIL max_model got=%0d/%0d exp=1/0", dcnt, mm); end
    endtask
`endif

    task automatic test_retrigger();
        int first, dcnt, bcnt, mm;
        do_reset();
        step();
        pulse_start();
`ifndef RWAIT_LFSR_EN
        checks++; if (wait_len !== 5'd8) begin errors++; $display("FAIL retrig_first_len got=%0d exp=8", wait_len); end
`endif
        observe(4, first, dcnt, bcnt, mm);
        checks++; if (dcnt != 0) begin errors++; $display("FAIL retrig_early_done got=%0d exp=0", dcnt); end
        pulse_start();
        checks++; if (rand_q !== m_r || wait_len !== m_len) begin errors++; $display("FAIL retrig_capture got=%0d/%0d exp=%0d/%0d", rand_q, wait_len, m_r, m_len); end
        observe(int'(m_len) + 4, first, dcnt, bcnt, mm);
        checks++; if (first != int'(m_len)) begin errors++; $display("FAIL retrig_done_edge got=%0d exp=%0d", first, m_len); end
        checks++; if (dcnt != 1 || mm != 0) begin errors++; $display("FAIL retrig_model got=%0d/%0d exp=1/0", dcnt, mm); end
    endtask

    task automatic test_abort();
        int first, dcnt, bcnt, mm;
        pulse_start();
        observe(2, first, dcnt, bcnt, mm);
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++; if (busy !== 1'b0 || rwait_done !== 1'b0) begin errors++; $display("FAIL abort_outputs got=%0b%0b exp=00", busy, rwait_done); end
        observe(20, first, dcnt, bcnt, mm);
        checks++; if (dcnt != 0 || mm != 0) begin errors++; $display("FAIL abort_no_done got=%0d/%0d exp=0/0", dcnt, mm); end
        for (int i = 0; i < 20 && model_src() == int'(m_r); i++) step();
        start_wait = 1'b1; abort = 1'b1;
        step();
        start_wait = 1'b0; abort = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_abort_busy got=%0b exp=0", busy); end
        checks++; if (rand_q !== m_r || wait_len !== m_len) begin errors++; $display("FAIL start_abort_hold got=%0d/%0d exp=%0d/%0d", rand_q, wait_len, m_r, m_len); end
        observe(3, first, dcnt, bcnt, mm);
        checks++; if (mm != 0) begin errors++; $display("FAIL start_abort_model got=%0d exp=0", mm); end
    endtask

    task automatic test_rst_mid();
        int first, dcnt, bcnt, mm;
        pulse_start();
        observe(2, first, dcnt, bcnt, mm);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (busy !== 1'b0 || rwait_done !== 1'b0) begin errors++; $display("FAIL rst_mid_flags got=%0b%0b exp=00", busy, rwait_done); end
        checks++; if (rand_q !== '0 || wait_len !== '0) begin errors++; $display("FAIL rst_mid_data got=%0d/%0d exp=0/0", rand_q, wait_len); end
        observe(40, first, dcnt, bcnt, mm);
        checks++; if (dcnt != 0 || mm != 0) begin errors++; $display("FAIL rst_mid_lost got=%0d/%0d exp=0/0", dcnt, mm); end
    endtask

    task automatic test_done_restart();
        int first, dcnt, bcnt, mm;
        bit seen;
        seen = 1'b0;
        pulse_start();
        for (int i = 0; i < 40 && !seen; i++) begin
            step();
            if (rwait_done === 1'b1) seen = 1'b1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL done_restart_seen got=0 exp=1"); end
        pulse_start();
        checks++; if (busy !== 1'b1 || rwait_done !== 1'b0) begin errors++; $display("FAIL done_restart_flags got=%0b%0b exp=10", busy, rwait_done); end
        observe(int'(m_len) + 4, first, dcnt, bcnt, mm);
        checks++; if (first != int'(m_len) || dcnt != 1) begin errors++; $display("FAIL done_restart_edge got=%0d/%0d exp=%0d/1", first, dcnt, m_len); end
        checks++; if (mm != 0) begin errors++; $display("FAIL done_restart_model got=%0d exp=0", mm); end
    endtask

    task automatic test_random_starts();
        int first, dcnt, bcnt, mm, exp_n;
        for (int k = 0; k < 100; k++) begin
            repeat ($urandom_range(0, 5)) step();
            pulse_start();
            exp_n = (int'(m_r) + 1) * (1 << SH);
            checks++; if (rand_q !== m_r || wait_len !== CW'(exp_n)) begin errors++; $display("FAIL rand_capture[%0d] got=%0d/%0d exp=%0d/%0d", k, rand_q, wait_len, m_r, exp_n); end
            observe(exp_n + 2, first, dcnt, bcnt, mm);
            checks++; if (first != exp_n || dcnt != 1) begin errors++; $display("FAIL rand_done[%0d] got=%0d/%0d exp=%0d/1", k, first, dcnt, exp_n); end
            checks++; if (mm != 0) begin errors++; $display("FAIL rand_model[%0d] got=%0d exp=0", k, mm); end
        end
    endtask

    initial begin
        test_reset();
        test_first_start();
`ifndef RWAIT_LFSR_EN
        test_source_max();
`endif
        test_retrigger();
        test_abort();
        test_rst_mid();
        test_done_restart();
        test_random_starts();
        $display("TB_RESULT checks=%0d failures=%0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
